wb_hb_master: RTL and testbench
===============================

Name: wb_hb_master

Overview:
- Wishbone slave that converts Wishbone single reads and writes into timed transactions on the asynchronous 16-bit host bus, acting as the host-bus master.
- It is the reverse-direction companion of the existing host-bus-to-Wishbone bridge.
- Sits between an on-chip Wishbone master (CPU or DMA) and an external host-bus peripheral.
- Timing is fixed by parameters and counted in clk cycles; the peripheral has no ready or wait signal.

Parameters:
- SETUP_CYC, 1: cycles with hb_cs low and address valid before the strobe; must be ≥ 1.
- ACCESS_CYC, 3: cycles hb_oe (read) or hb_we (write) is held low; must be ≥ 1.
- HOLD_CYC, 1: cycles after the strobe rises while hb_cs stays low and write data stays driven; must be ≥ 1.
- CNT_W, 4: phase-counter width; must satisfy 2^CNT_W > max(SETUP_CYC, ACCESS_CYC, HOLD_CYC).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_cycle  in  1  Wishbone cycle valid.
- wb_strobe  in  1  Wishbone strobe.
- wb_write  in  1  1 = write, 0 = read.
- wb_addr  in  16  word address.
- wb_wrData  in  16  write data.
- wb_rdData  out  16  read data, registered.
- wb_ack  out  1  single-cycle acknowledge, registered.
- hb_cs  out  1  host-bus chip select, active low.
- hb_oe  out  1  host-bus output enable, active low.
- hb_we  out  1  host-bus write enable, active low.
- hb_addr  out  16  host-bus address.
- hb_data  inout  16  host-bus data; driven only during the write phases, high-Z otherwise.

Behaviour:
- Reset (asynchronous, active high): state IDLE; hb_cs=hb_oe=hb_we=1; hb_addr=0; hb_data high-Z; wb_ack=0; wb_rdData=0; latched write flag and data cleared.
- Every output except hb_data is driven directly from a flop. The hb_data output-enable is also a flop.
- FSM states: IDLE, SETUP, ACCESS, HOLD, ACK.
- IDLE:
  - hb_cs=1; data high-Z.
  - If wb_cycle & wb_strobe: latch wb_addr into hb_addr; latch wb_write and wb_wrData; load the counter with SETUP_CYC-1; go to SETUP.
- SETUP:
  - hb_cs=0; hb_oe=hb_we=1.
  - For a write, hb_data is driven with the latched data.
  - Held for SETUP_CYC cycles, then load the counter with ACCESS_CYC-1 and go to ACCESS.
- ACCESS:
  - Read: hb_oe=0. Write: hb_we=0 and data stays driven.
  - Held for ACCESS_CYC cycles.
  - For a read, hb_data is sampled into wb_rdData on the clock edge that leaves ACCESS (last ACCESS cycle).
  - Then load the counter with HOLD_CYC-1 and go to HOLD.
- HOLD:
  - hb_oe=hb_we=1; hb_cs=0; write data still driven.
  - After HOLD_CYC cycles go to ACK.
- ACK:
  - hb_cs=1; data high-Z.
  - wb_ack=1 for exactly one cycle, but only if wb_cycle & wb_strobe are still high.
  - Then go to IDLE unconditionally.
- Latency: with the request accepted at edge E0, wb_ack is high in the cycle after edge E0+SETUP_CYC+ACCESS_CYC+HOLD_CYC. With defaults that is 5 cycles.
- Hardware counts of each phase:
  - hb_cs low for SETUP_CYC+ACCESS_CYC+HOLD_CYC cycles.
  - hb_oe or hb_we low for exactly ACCESS_CYC cycles.
- hb_oe and hb_we are never low simultaneously. hb_oe/hb_we are never low while hb_cs is high.
- Back-to-back requests: the ACK→IDLE step guarantees at least one cycle with hb_cs high between transactions. The earliest next acceptance is the IDLE cycle after ACK.
- Abort (wb_cycle or wb_strobe drops mid-transfer): the host-bus sequence completes unchanged, because the external bus cannot be cut. No wb_ack is issued. Read data is still captured into wb_rdData.
- Inputs changing after acceptance (wb_addr, wb_wrData, wb_write): ignored until the next IDLE.
- wb_rdData holds its last read value; writes do not alter it.
- Reset mid-transfer: immediate return to reset values. hb_cs/hb_oe/hb_we rise and hb_data goes high-Z asynchronously.

Decomposition:
- Shared package wb_hb_pkg:
  - FSM state encoding.
  - Default timing constants (SETUP_CYC, ACCESS_CYC, HOLD_CYC).
  - Bus width constant (16).
- One natural sub-module, hb_phase_counter: a loadable down-counter of width CNT_W with a zero flag, used for all three timed phases.

Test Plan:
- Reset → hb_cs/hb_oe/hb_we = 1, hb_data = Z, wb_ack = 0, wb_rdData = 0. Assert rst during IDLE and again mid-ACCESS; all revert immediately.
- Read at wb_addr=16'h0003 with the peripheral model driving 16'h1234 → hb_addr=16'h0003; hb_cs low 5 cycles; hb_oe low exactly 3 cycles; wb_ack a single pulse 5 cycles after acceptance; wb_rdData=16'h1234.
- Write 16'hF0F0 to 16'h0010 → hb_we low exactly 3 cycles; hb_data=16'hF0F0 for all 5 hb_cs-low cycles and Z otherwise; hb_oe stays 1; wb_rdData unchanged.
- Back-to-back read then write with strobe held → at least one hb_cs-high cycle between them; two wb_ack pulses; no overlap of hb_oe and hb_we.
- Abort: drop wb_strobe during ACCESS → host-bus sequence completes with full timing; wb_ack never asserted; FSM back in IDLE and accepts the next request.
- Parameter override SETUP=2, ACCESS=5, HOLD=2, read → hb_cs low 9 cycles; hb_oe low 5 cycles; wb_ack 9 cycles after acceptance.

Source files
------------

// File: rtl/wb_hb_pkg.sv
// Shared definitions for the Wishbone-to-host-bus master: phase FSM encoding,
// default host-bus timing and the bus width.
package wb_hb_pkg;

    localparam int BUS_W          = 16;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_ACCESS_CYC = 3;
    localparam int DEF_HOLD_CYC   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_ACK
    } hb_state_e;

endpackage

// File: rtl/hb_phase_counter.sv
// Loadable down-counter with a zero flag; times the setup, access and hold phases.
module hb_phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign zero = (count_q == '0);

    // Parks at zero so a finished phase never wraps around.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (!zero) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_hb_master.sv
// Wishbone slave that replays each single read/write as a fixed-timing
// transaction on the asynchronous 16-bit host bus (setup, access, hold).
module wb_hb_master
    import wb_hb_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int ACCESS_CYC = DEF_ACCESS_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cycle,
    input  logic             wb_strobe,
    input  logic             wb_write,
    input  logic [BUS_W-1:0] wb_addr,
    input  logic [BUS_W-1:0] wb_wrData,
    output logic [BUS_W-1:0] wb_rdData,
    output logic             wb_ack,
    output logic             hb_cs,
    output logic             hb_oe,
    output logic             hb_we,
    output logic [BUS_W-1:0] hb_addr,
    inout  wire logic [BUS_W-1:0] hb_data
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    hb_state_e        state_q, state_d;
    logic             hb_cs_q, hb_cs_d;
    logic             hb_oe_q, hb_oe_d;
    logic             hb_we_q, hb_we_d;
    logic [BUS_W-1:0] hb_addr_q, hb_addr_d;
    logic             data_oe_q, data_oe_d;
    logic             wr_flag_q, wr_flag_d;
    logic [BUS_W-1:0] wr_data_q, wr_data_d;
    logic             ack_q, ack_d;
    logic [BUS_W-1:0] rd_data_q, rd_data_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             req;

    assign req = wb_cycle & wb_strobe;

    hb_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Every strobe/enable is computed one edge early so the pins come straight from flops.
    always_comb begin
        state_d   = state_q;
        hb_cs_d   = hb_cs_q;
        hb_oe_d   = hb_oe_q;
        hb_we_d   = hb_we_q;
        hb_addr_d = hb_addr_q;
        data_oe_d = data_oe_q;
        wr_flag_d = wr_flag_q;
        wr_data_d = wr_data_q;
        ack_d     = 1'b0;
        rd_data_d = rd_data_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    hb_addr_d = wb_addr;
                    wr_flag_d = wb_write;
                    wr_data_d = wb_wrData;
                    hb_cs_d   = 1'b0;
                    data_oe_d = wb_write;
                    cnt_load  = 1'b1;
                    cnt_val   = SETUP_LD;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    hb_oe_d  = wr_flag_q;
                    hb_we_d  = !wr_flag_q;
                    cnt_load = 1'b1;
                    cnt_val  = ACCESS_LD;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    if (!wr_flag_q) begin
                        rd_data_d = hb_data;
                    end
                    hb_oe_d  = 1'b1;
                    hb_we_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    hb_cs_d   = 1'b1;
                    data_oe_d = 1'b0;
                    // An aborted request still runs the bus but is not acknowledged.
                    ack_d     = req;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hb_cs_q   <= 1'b1;
            hb_oe_q   <= 1'b1;
            hb_we_q   <= 1'b1;
            hb_addr_q <= '0;
            data_oe_q <= 1'b0;
            wr_flag_q <= 1'b0;
            wr_data_q <= '0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hb_cs_q   <= hb_cs_d;
            hb_oe_q   <= hb_oe_d;
            hb_we_q   <= hb_we_d;
            hb_addr_q <= hb_addr_d;
            data_oe_q <= data_oe_d;
            wr_flag_q <= wr_flag_d;
            wr_data_q <= wr_data_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign hb_cs     = hb_cs_q;
    assign hb_oe     = hb_oe_q;
    assign hb_we     = hb_we_q;
    assign hb_addr   = hb_addr_q;
    assign wb_ack    = ack_q;
    assign wb_rdData = rd_data_q;
    assign hb_data   = data_oe_q ? wr_data_q : {BUS_W{1'bz}};

endmodule

// File: tb/tb_wb_hb_master.sv
// Bench for wb_hb_master: default-timing instance plus a 2/5/2 instance, each
// with a pulled-up host bus and a memory-backed peripheral.
module tb_wb_hb_master;

    typedef struct {
        int          inst;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } host_t;

    typedef struct {
        int          inst;
        int          ack_cyc;
        logic [15:0] rd;
    } ack_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT wiring ----------------
    logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
    logic        wb_write = 1'b0;
    logic [15:0] wb_addr = '0, wb_wrData = '0;
    logic [15:0] rd0, rd1, addr0, addr1;
    logic        ack0, ack1, cs0, cs1, oe0, oe1, we0, we1;
    wire  [15:0] data0, data1;

    logic [15:0] pmem [2][256];
    logic [15:0] model_mem [2][256];
    logic [15:0] last_rd [2];
    int          model_free [2];

    pullup (data0);
    pullup (data1);
    assign data0 = (!cs0 && !oe0) ? pmem[0][addr0[7:0]] : 16'hzzzz;
    assign data1 = (!cs1 && !oe1) ? pmem[1][addr1[7:0]] : 16'hzzzz;

    wb_hb_master dut0 (
        .clk(clk), .rst(rst), .wb_cycle(cyc0), .wb_strobe(stb0), .wb_write(wb_write),
        .wb_addr(wb_addr), .wb_wrData(wb_wrData), .wb_rdData(rd0), .wb_ack(ack0),
        .hb_cs(cs0), .hb_oe(oe0), .hb_we(we0), .hb_addr(addr0), .hb_data(data0)
    );

    wb_hb_master #(.SETUP_CYC(2), .ACCESS_CYC(5), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .wb_cycle(cyc1), .wb_strobe(stb1), .wb_write(wb_write),
        .wb_addr(wb_addr), .wb_wrData(wb_wrData), .wb_rdData(rd1), .wb_ack(ack1),
        .hb_cs(cs1), .hb_oe(oe1), .hb_we(we1), .hb_addr(addr1), .hb_data(data1)
    );

    logic        cs_a [2], oe_a [2], we_a [2], ack_a [2];
    logic [15:0] rd_a [2], addr_a [2], d_a [2];
    assign cs_a[0] = cs0;   assign cs_a[1] = cs1;
    assign oe_a[0] = oe0;   assign oe_a[1] = oe1;
    assign we_a[0] = we0;   assign we_a[1] = we1;
    assign ack_a[0] = ack0; assign ack_a[1] = ack1;
    assign rd_a[0] = rd0;   assign rd_a[1] = rd1;
    assign addr_a[0] = addr0; assign addr_a[1] = addr1;
    assign d_a[0] = data0;  assign d_a[1] = data1;

    // ---------------- reference timing ----------------
    function automatic int tot_cyc(input int i);
        return (i == 0) ? (1 + 3 + 1) : (2 + 5 + 2);
    endfunction

    function automatic int acc_cyc(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    // ---------------- scoreboard ----------------
    host_t host_q [$];
    ack_t  ack_q [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Host-bus monitor: phase lengths, address, data drive and bus release.
    host_t cur [2];
    bit    in_txn [2];
    int    cs_cnt [2], oe_cnt [2], we_cnt [2];
    bit    pmem_loaded = 0;

    always @(negedge clk) begin
        if (!pmem_loaded) begin
            pmem = model_mem;
            pmem_loaded = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                in_txn[i] = 0;
            end else begin
                chk($sformatf("oe_we_overlap%0d", i), {31'd0, oe_a[i] | we_a[i]}, 32'd1);
                chk($sformatf("strobe_outside_cs%0d", i),
                    {31'd0, cs_a[i] & (!oe_a[i] | !we_a[i])}, 32'd0);
                if (!cs_a[i]) begin
                    if (!in_txn[i]) begin
                        if (host_q.size() == 0 || host_q[0].inst != i) begin
                            chk($sformatf("unexpected_cs_low%0d", i), {31'd0, cs_a[i]}, 32'd1);
                        end else begin
                            cur[i] = host_q.pop_front();
                            in_txn[i] = 1;
                            cs_cnt[i] = 0;
                            oe_cnt[i] = 0;
                            we_cnt[i] = 0;
                        end
                    end
                    if (in_txn[i]) begin
                        cs_cnt[i]++;
                        if (!oe_a[i]) oe_cnt[i]++;
                        if (!we_a[i]) begin
                            we_cnt[i]++;
                            pmem[i][addr_a[i][7:0]] = d_a[i];
                        end
                        chk($sformatf("hb_addr%0d", i), {16'd0, addr_a[i]}, {16'd0, cur[i].addr});
                        if (cur[i].wr) begin
                            chk($sformatf("wr_data_driven%0d", i), {16'd0, d_a[i]}, {16'd0, cur[i].data});
                        end else if (oe_a[i]) begin
                            chk($sformatf("rd_bus_released%0d", i), {16'd0, d_a[i]}, 32'hffff);
                        end
                    end
                end else begin
                    chk($sformatf("idle_bus_released%0d", i), {16'd0, d_a[i]}, 32'hffff);
                    if (in_txn[i]) begin
                        in_txn[i] = 0;
                        chk($sformatf("cs_low_cycles%0d", i), cs_cnt[i], tot_cyc(i));
                        chk($sformatf("oe_low_cycles%0d", i), oe_cnt[i], cur[i].wr ? 0 : acc_cyc(i));
                        chk($sformatf("we_low_cycles%0d", i), we_cnt[i], cur[i].wr ? acc_cyc(i) : 0);
                    end
                end
            end
        end
    end

    // Wishbone monitor: each ack must land on its predicted cycle with the right read data.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                if (ack_q.size() != 0 && ack_q[0].inst == i && ack_q[0].ack_cyc < cyc_cnt) begin
                    chk($sformatf("missing_ack%0d", i), 32'd0, 32'd1);
                    void'(ack_q.pop_front());
                end
                if (ack_a[i]) begin
                    if (ack_q.size() == 0 || ack_q[0].inst != i || ack_q[0].ack_cyc != cyc_cnt) begin
                        chk($sformatf("unexpected_ack%0d", i), 32'd1, 32'd0);
                    end else begin
                        ack_t a;
                        a = ack_q.pop_front();
                        chk($sformatf("ack_rdData%0d", i), {16'd0, rd_a[i]}, {16'd0, a.rd});
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) begin
            cyc0 = v; stb0 = v;
        end else begin
            cyc1 = v; stb1 = v;
        end
    endtask

    // abort_k > 0 drops the strobe after edge e0+abort_k; keep leaves the strobe up for a follow-on request.
    task automatic do_txn(input int i, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data, input int abort_k, input logic keep);
        int    e0;
        host_t h;
        ack_t  a;
        while (cyc_cnt + 1 < model_free[i]) next_cyc();
        e0 = cyc_cnt + 1;
        h.inst = i;
        h.wr   = wr;
        h.addr = addr;
        h.data = wr ? data : model_mem[i][addr[7:0]];
        if (wr) model_mem[i][addr[7:0]] = data;
        else    last_rd[i] = model_mem[i][addr[7:0]];
        host_q.push_back(h);
        if (abort_k == 0) begin
            a.inst = i;
            a.ack_cyc = e0 + tot_cyc(i);
            a.rd = last_rd[i];
            ack_q.push_back(a);
        end
        model_free[i] = e0 + tot_cyc(i) + 2;
        wb_write = wr; wb_addr = addr; wb_wrData = data;
        set_req(i, 1'b1);
        next_cyc();
        wb_addr = 16'($urandom);
        wb_wrData = 16'($urandom);
        wb_write = 1'($urandom_range(0, 1));
        while (cyc_cnt < e0 + tot_cyc(i) + 1) begin
            if (abort_k != 0 && cyc_cnt >= e0 + abort_k) begin
                if (i == 0) stb0 = 1'b0;
                else        stb1 = 1'b0;
            end
            next_cyc();
        end
        if (!keep || abort_k != 0) set_req(i, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_cs%0d", tag, i), {31'd0, cs_a[i]}, 32'd1);
            chk($sformatf("%s_oe%0d", tag, i), {31'd0, oe_a[i]}, 32'd1);
            chk($sformatf("%s_we%0d", tag, i), {31'd0, we_a[i]}, 32'd1);
            chk($sformatf("%s_ack%0d", tag, i), {31'd0, ack_a[i]}, 32'd0);
            chk($sformatf("%s_rdData%0d", tag, i), {16'd0, rd_a[i]}, 32'd0);
            chk($sformatf("%s_addr%0d", tag, i), {16'd0, addr_a[i]}, 32'd0);
            chk($sformatf("%s_data_z%0d", tag, i), {16'd0, d_a[i]}, 32'hffff);
        end
    endtask

    task automatic apply_reset_model();
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = '0;
            model_free[i] = cyc_cnt + 2;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        host_t h;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) model_mem[i][k] = 16'($urandom);
            last_rd[i] = '0;
            model_free[i] = 0;
        end
        model_mem[0][3] = 16'h1234;

        rst = 1'b1;
        repeat (3) next_cyc();
        check_reset_outputs("reset_init");
        rst = 1'b0;
        apply_reset_model();
        next_cyc();

        do_txn(0, 1'b0, 16'h0003, 16'h0000, 0, 1'b0);
        do_txn(0, 1'b1, 16'h0010, 16'hF0F0, 0, 1'b0);
        next_cyc();
        do_txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b1);
        do_txn(0, 1'b1, 16'h0020, 16'hA5A5, 0, 1'b0);
        do_txn(0, 1'b0, 16'h0003, 16'h0000, 2, 1'b0);
        do_txn(0, 1'b0, 16'h0020, 16'h0000, 0, 1'b0);

        // Reset while idle.
        while (cyc_cnt + 1 < model_free[0]) next_cyc();
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_idle");
        next_cyc();
        rst = 1'b0;
        apply_reset_model();
        next_cyc();

        // Reset in the middle of an ACCESS phase.
        e0 = cyc_cnt + 1;
        h.inst = 0; h.wr = 1'b0; h.addr = 16'h0005; h.data = model_mem[0][5];
        host_q.push_back(h);
        wb_write = 1'b0; wb_addr = 16'h0005;
        set_req(0, 1'b1);
        while (cyc_cnt < e0 + 2) next_cyc();
        chk("mid_access_oe_low", {31'd0, oe0}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_access");
        set_req(0, 1'b0);
        next_cyc();
        rst = 1'b0;
        apply_reset_model();
        next_cyc();

        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic [15:0] a, d;
            int          ab, gap;
            wr  = 1'($urandom_range(0, 1));
            a   = 16'($urandom_range(0, 15));
            d   = 16'($urandom);
            ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
            gap = (n == 39) ? 1 : $urandom_range(0, 2);
            do_txn(0, wr, a, d, ab, gap == 0);
            repeat (gap) next_cyc();
        end

        do_txn(1, 1'b0, 16'h0003, 16'h0000, 0, 1'b0);
        do_txn(1, 1'b1, 16'h0040, 16'h5AC3, 0, 1'b1);
        do_txn(1, 1'b0, 16'h0040, 16'h0000, 0, 1'b0);
        do_txn(1, 1'b0, 16'h0041, 16'h0000, 3, 1'b0);
        do_txn(1, 1'b1, 16'h0042, 16'h0F0F, 0, 1'b0);

        repeat (20) next_cyc();
        chk("host_queue_drained", host_q.size(), 32'd0);
        chk("ack_queue_drained", ack_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
